dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester controller for the single-port data memory: CPU load/store port (port 0) and debug/loader port (port 1).
- Arbitrates requests, latches address/data, and sequences MemR/MemW strobes to the memory.
- Waits a fixed read latency, then returns read data to the winning requester with a one-cycle valid pulse.
- Sits between the CPU datapath and the data memory.

Parameters:
- ADDR_W, 32, address width passed through to memory unmodified.
- DATA_W, 32, data width.
- RD_LAT, 1, cycles from the first MemR cycle to the edge where mem_rdata is sampled. Legal range 1..8; out of range → elaboration $error.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request.
- cpu_we  in  1  1=store, 0=load.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  one-cycle accept pulse.
- cpu_rvalid  out  1  one-cycle load-data-valid pulse.
- cpu_rdata  out  DATA_W  load data.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rvalid, dbg_rdata: same as cpu_* for port 1.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_MemR  out  1  memory read strobe.
- mem_MemW  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Single clock domain: clk.
- Reset is asynchronous and active-low: rst_n low forces state IDLE immediately.
- Reset values: all gnt/rvalid/MemR/MemW = 0; mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0; owner = 0; last_owner = 1.
- FSM: IDLE → ISSUE → (write) IDLE, or (read) WAIT → RESP → IDLE.
- IDLE:
  - Sample cpu_req/dbg_req at each edge.
  - If any is high: pick the winner, latch its addr/wdata/we/id into mem_addr/mem_wdata/we_q/owner, go ISSUE.
  - No request → stay IDLE.
- ISSUE (1 cycle):
  - gnt of owner = 1.
  - mem_MemW = we_q, mem_MemR = !we_q.
  - Write → IDLE.
  - Read → WAIT if RD_LAT > 1; else sample mem_rdata at this edge → RESP.
- WAIT:
  - mem_MemR held high; counter runs RD_LAT-1 cycles.
  - At the last WAIT edge, capture mem_rdata into the owner's rdata → RESP.
- RESP (1 cycle): owner's rvalid = 1, strobes low → IDLE.
- Timing: gnt in cycle k; load rvalid in cycle k+RD_LAT. Store occupancy 2 cycles; load occupancy 2+RD_LAT cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it sees gnt.
  - Requester drops req at the edge ending the gnt cycle. A req still high in the following IDLE is a new access.
  - Requests arriving while busy are not sampled; they wait.
- Outputs are registered.
  - mem_addr/mem_wdata hold the last latched value between accesses.
  - Non-owner rdata is never modified.
- Arbitration (default, fixed priority): both req in IDLE → CPU wins; dbg waits.
- Reset mid-operation: strobes and pulses drop asynchronously; pending load is discarded with no rvalid; after release the FSM starts from IDLE.
- Address and data pass through unmodified: no alignment check, no byte lanes.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On simultaneous requests, the port != last_owner wins.
  - last_owner updates at each ISSUE entry.
  - Reset value 1, so CPU wins the first tie.
- Undefined: fixed priority CPU > dbg; last_owner register is not built.

Test Plan:
- Reset, then CPU store addr=0x10 data=0xDEADBEEF → cpu_gnt 1 cycle; mem_MemW=1 for exactly 1 cycle with mem_addr=0x10, mem_wdata=0xDEADBEEF; busy 1 cycle; no rvalid.
- RD_LAT=1: CPU load addr=0x10 after the store, memory model returning stored data → cpu_rvalid 1 cycle after cpu_gnt, cpu_rdata=0xDEADBEEF; dbg_rvalid stays 0.
- RD_LAT=3: dbg load addr=0x20 holding 0x12345678 → mem_MemR high 3 cycles; dbg_rvalid 3 cycles after dbg_gnt; dbg_rdata=0x12345678; cpu_rdata unchanged.
- cpu_req and dbg_req both held, both store:
  - Without DMEM_ARB_RR_EN: CPU granted first, dbg on the next IDLE.
  - With DMEM_ARB_RR_EN, both held continuously for 4 accesses: grants alternate cpu, dbg, cpu, dbg.
- cpu_req asserted while a dbg load is in WAIT → no cpu_gnt until dbg_rvalid has pulsed; cpu_gnt in the cycle after RESP+IDLE sample.
- rst_n pulled low during WAIT of a load → mem_MemR drops immediately, no rvalid ever pulses for that load; after release, a new CPU store completes normally.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: CPU (port 0) / debug (port 1) arbiter and MemR/MemW sequencer for the single-port data memory.
// Latency: gnt one cycle after req is sampled in IDLE; load rvalid RD_LAT cycles after gnt. Backpressure: requests are only sampled in IDLE and wait otherwise.
// Optional DMEM_ARB_RR_EN: round-robin on simultaneous requests (default fixed priority CPU > dbg).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_MemR,
    output logic              mem_MemW,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > 8) begin : g_lat_chk
        $error("dmem_arbiter: RD_LAT must be in 1..8");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // WAIT lasts RD_LAT-1 cycles; the counter is loaded on the way out of ISSUE.
    localparam logic [2:0] WAIT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

    state_t     state_q, state_d;
    logic [2:0] cnt_q;
    logic       we_q, owner_q;
    logic       take, capture, win_dbg, sel_we, tie_dbg;
    logic       cpu_gnt_d, dbg_gnt_d, cpu_rvalid_d, dbg_rvalid_d, memr_d, memw_d;

`ifdef DMEM_ARB_RR_EN
    logic last_owner;

    assign tie_dbg = ~last_owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= 1'b1;
        end else if (take) begin
            last_owner <= win_dbg;
        end
    end
`else
    assign tie_dbg = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        take         = 1'b0;
        capture      = 1'b0;
        win_dbg      = 1'b0;
        sel_we       = 1'b0;
        cpu_gnt_d    = 1'b0;
        dbg_gnt_d    = 1'b0;
        cpu_rvalid_d = 1'b0;
        dbg_rvalid_d = 1'b0;
        memr_d       = 1'b0;
        memw_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dbg_req) begin
                    take      = 1'b1;
                    win_dbg   = dbg_req && (!cpu_req || tie_dbg);
                    sel_we    = win_dbg ? dbg_we : cpu_we;
                    cpu_gnt_d = !win_dbg;
                    dbg_gnt_d = win_dbg;
                    memw_d    = sel_we;
                    memr_d    = !sel_we;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = IDLE;
                end else if (RD_LAT == 1) begin
                    capture      = 1'b1;
                    cpu_rvalid_d = !owner_q;
                    dbg_rvalid_d = owner_q;
                    state_d      = RESP;
                end else begin
                    memr_d  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    capture      = 1'b1;
                    cpu_rvalid_d = !owner_q;
                    dbg_rvalid_d = owner_q;
                    state_d      = RESP;
                end else begin
                    memr_d = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cpu_gnt    <= 1'b0;
            dbg_gnt    <= 1'b0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
            mem_MemR   <= 1'b0;
            mem_MemW   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpu_gnt    <= cpu_gnt_d;
            dbg_gnt    <= dbg_gnt_d;
            cpu_rvalid <= cpu_rvalid_d;
            dbg_rvalid <= dbg_rvalid_d;
            mem_MemR   <= memr_d;
            mem_MemW   <= memw_d;
            busy       <= (state_d != IDLE);
        end
    end

    // Address/data hold their last latched value between accesses; only the owner's rdata moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            cnt_q     <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else begin
            if (take) begin
                owner_q   <= win_dbg;
                we_q      <= sel_we;
                mem_addr  <= win_dbg ? dbg_addr : cpu_addr;
                mem_wdata <= win_dbg ? dbg_wdata : cpu_wdata;
            end
            if (state_q == ISSUE) begin
                cnt_q <= WAIT_INIT;
            end else if (state_q == WAIT && cnt_q != 3'd0) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (capture && owner_q) begin
                dbg_rdata <= mem_rdata;
            end
            if (capture && !owner_q) begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule
